// File: rtl/multiplier_seq_if.sv
// multiplier_seq_if: operand/result valid-ready handshake bundle for multiplier_seq
interface multiplier_seq_if #(parameter int N = 4);
  logic           in_valid;
  logic           in_ready;
  logic           in_signed;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;
  modport master (
    output in_valid, in_signed, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product, busy
  );
  modport slave (
    input  in_valid, in_signed, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/multiplier_seq.sv
// multiplier_seq: N-bit shift-and-add multiplier with valid/ready in and out; MULTIPLIER_SIGNED_EN adds per-op signed mode
module multiplier_seq #(
  parameter int N = 4
) (
  input logic             clock,
  input logic             n_reset,
  multiplier_seq_if.slave bus
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q;
  logic [N-1:0]  a_q, q_q, m_q, addend;
  logic [CW-1:0] count_q;
  logic [N:0]    sum_d;
  logic          last;
  assign last   = count_q == CW'(N - 1);
  assign addend = q_q[0] ? m_q : '0;
`ifdef MULTIPLIER_SIGNED_EN
  logic sgn_q;
  // the final iteration subtracts because Q's top bit carries negative weight
  always_comb
    sum_d = !sgn_q ? {1'b0, a_q} + {1'b0, addend}
          : last   ? {a_q[N-1], a_q} - {addend[N-1], addend}
          :          {a_q[N-1], a_q} + {addend[N-1], addend};
`else
  // N+1-bit sum keeps the carry so the shift preserves it
  always_comb sum_d = {1'b0, a_q} + {1'b0, addend};
`endif
  // controller and datapath: accept in IDLE, iterate N times, hold result in DONE
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
`ifdef MULTIPLIER_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE:
          if (bus.in_valid) begin
            a_q     <= '0;
            q_q     <= bus.multiplier;
            m_q     <= bus.multiplicand;
            count_q <= '0;
`ifdef MULTIPLIER_SIGNED_EN
            sgn_q   <= bus.in_signed;
`endif
            state_q <= RUN;
          end
        RUN: begin
          {a_q, q_q} <= {sum_d, q_q[N-1:1]};
          count_q    <= count_q + 1'b1;
          if (last) state_q <= DONE;
        end
        DONE:
          if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q != IDLE;
  assign bus.product   = {a_q, q_q};
endmodule

// File: tb/tb_multiplier_seq.sv
// tb_multiplier_seq: directed self-checking bench for multiplier_seq at N=4 and N=8
module tb_multiplier_seq;
  logic clock = 1'b0;
  logic n_reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  multiplier_seq_if #(.N(4)) b4 ();
  multiplier_seq_if #(.N(8)) b8 ();
  multiplier_seq #(.N(4)) u4 (.clock(clock), .n_reset(n_reset), .bus(b4));
  multiplier_seq #(.N(8)) u8 (.clock(clock), .n_reset(n_reset), .bus(b8));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input int w, input logic [7:0] mc, input logic [7:0] mp, input logic s,
                       input logic [15:0] exp, input string tag);
    int cyc;
    @(negedge clock);
    if (w == 4) begin
      b4.in_valid = 1'b1; b4.multiplicand = mc[3:0]; b4.multiplier = mp[3:0]; b4.in_signed = s;
    end else begin
      b8.in_valid = 1'b1; b8.multiplicand = mc; b8.multiplier = mp; b8.in_signed = s;
    end
    @(negedge clock);
    b4.in_valid = 1'b0;
    b8.in_valid = 1'b0;
    b4.multiplicand = '0; b4.multiplier = '0;
    b8.multiplicand = '0; b8.multiplier = '0;
    cyc = 0;
    while (!(w == 4 ? b4.out_valid : b8.out_valid) && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(w));
    check({tag, " product"}, w == 4 ? 64'(b4.product) : 64'(b8.product), 64'(exp));
    b4.out_ready = 1'b1;
    b8.out_ready = 1'b1;
    @(negedge clock);
    b4.out_ready = 1'b0;
    b8.out_ready = 1'b0;
    check({tag, " idle"}, w == 4 ? 64'(b4.in_ready) : 64'(b8.in_ready), 64'd1);
  endtask
  initial begin
    logic [3:0] bb_mc [3];
    logic [3:0] bb_mp [3];
    logic [7:0] bb_exp [3];
    int         seen, last_cyc;
    b4.in_valid = 0; b4.in_signed = 0; b4.multiplicand = 0; b4.multiplier = 0; b4.out_ready = 0;
    b8.in_valid = 0; b8.in_signed = 0; b8.multiplicand = 0; b8.multiplier = 0; b8.out_ready = 0;
    #12;
    check("rst in_ready", 64'(b4.in_ready), 64'd1);
    check("rst out_valid", 64'(b4.out_valid), 64'd0);
    check("rst busy", 64'(b4.busy), 64'd0);
    check("rst product", 64'(b4.product), 64'd0);
    check("rst product8", 64'(b8.product), 64'd0);
    @(negedge clock);
    n_reset = 1'b1;
    do_op(4, 8'd13, 8'd11, 1'b0, 16'h8F, "u13x11");
    do_op(4, 8'd15, 8'd15, 1'b0, 16'hE1, "u15x15");
    do_op(4, 8'h8, 8'h7, 1'b0, 16'h38, "u8x7");
    do_op(4, 8'h8, 8'h8, 1'b0, 16'h40, "u8x8");
    do_op(4, 8'd0, 8'd9, 1'b0, 16'h00, "u0x9");
`ifdef MULTIPLIER_SIGNED_EN
    do_op(4, 8'h8, 8'h7, 1'b1, 16'hC8, "s-8x7");
    do_op(4, 8'h8, 8'h8, 1'b1, 16'h40, "s-8x-8");
    do_op(4, 8'h5, 8'hD, 1'b1, 16'hF1, "s5x-3");
    do_op(8, 8'h80, 8'h80, 1'b1, 16'h4000, "s8 -128x-128");
`endif
    do_op(8, 8'hFF, 8'hFF, 1'b0, 16'hFE01, "u8 255x255");
    do_op(8, 8'h00, 8'hAB, 1'b0, 16'h0000, "u8 0xAB");
    // backpressure: hold DONE for 10 cycles while poking in_valid
    @(negedge clock);
    b4.in_valid = 1'b1; b4.multiplicand = 4'd6; b4.multiplier = 4'd6; b4.in_signed = 1'b0;
    @(negedge clock);
    b4.in_valid = 1'b0;
    seen = 0;
    while (!b4.out_valid && seen < 40) begin
      @(negedge clock);
      seen++;
    end
    check("bp latency", 64'(seen), 64'd4);
    b4.multiplicand = 4'd1; b4.multiplier = 4'd1;
    for (int i = 0; i < 10; i++) begin
      b4.in_valid = (i % 2 == 0);
      @(negedge clock);
      check("bp out_valid", 64'(b4.out_valid), 64'd1);
      check("bp product", 64'(b4.product), 64'h24);
      check("bp in_ready", 64'(b4.in_ready), 64'd0);
    end
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    @(negedge clock);
    b4.out_ready = 1'b0;
    check("bp release in_ready", 64'(b4.in_ready), 64'd1);
    check("bp release out_valid", 64'(b4.out_valid), 64'd0);
    check("bp retained product", 64'(b4.product), 64'h24);
    // back-to-back: in_valid held high across three operations
    bb_mc[0] = 4'd3; bb_mp[0] = 4'd5; bb_exp[0] = 8'h0F;
    bb_mc[1] = 4'd2; bb_mp[1] = 4'd7; bb_exp[1] = 8'h0E;
    bb_mc[2] = 4'd9; bb_mp[2] = 4'd9; bb_exp[2] = 8'h51;
    @(negedge clock);
    b4.in_valid = 1'b1; b4.out_ready = 1'b1;
    b4.multiplicand = bb_mc[0]; b4.multiplier = bb_mp[0];
    seen = 0;
    last_cyc = 0;
    for (int c = 0; c < 60 && seen < 3; c++) begin
      @(negedge clock);
      if (b4.out_valid) begin
        check("b2b product", 64'(b4.product), 64'(bb_exp[seen]));
        if (seen > 0) check("b2b spacing", 64'(c - last_cyc), 64'd6);
        last_cyc = c;
        seen++;
        if (seen < 3) begin
          b4.multiplicand = bb_mc[seen];
          b4.multiplier = bb_mp[seen];
        end else b4.in_valid = 1'b0;
      end
    end
    check("b2b count", 64'(seen), 64'd3);
    @(negedge clock);
    b4.out_ready = 1'b0;
    // asynchronous reset two cycles into a run
    @(negedge clock);
    b4.in_valid = 1'b1; b4.multiplicand = 4'd13; b4.multiplier = 4'd11;
    @(negedge clock);
    b4.in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("mid busy", 64'(b4.busy), 64'd1);
    n_reset = 1'b0;
    #1;
    check("arst in_ready", 64'(b4.in_ready), 64'd1);
    check("arst out_valid", 64'(b4.out_valid), 64'd0);
    check("arst busy", 64'(b4.busy), 64'd0);
    check("arst product", 64'(b4.product), 64'd0);
    @(negedge clock);
    n_reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (b4.out_valid) seen++;
    end
    check("arst no out_valid", 64'(seen), 64'd0);
    do_op(4, 8'd3, 8'd5, 1'b0, 16'h0F, "post-rst 3x5");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multiplier_seq.md
# multiplier_seq

Self-contained sequential shift-and-add multiplier: a parametrised successor to the team's fixed 4-bit datapath. It integrates its own controller and iteration counter, and adds valid/ready handshakes on both input and output. Per-operation signed (two's-complement) multiplication is available when compiled in. It sits between an operand producer and a result consumer, both using standard valid/ready flow control.

## Interface
- N, default 4: operand width in bits; legal N >= 2; product is 2N bits.
- clock  input  1  rising-edge clock for all state.
- n_reset  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept operands; equals (state == IDLE).
- in_signed  input  1  treat operands as two's-complement; sampled with the operands.
- multiplicand  input  N  operand M.
- multiplier  input  N  operand Q.
- out_valid  output  1  product valid; equals (state == DONE).
- out_ready  input  1  consumer accepts product.
- product  output  2N  {a, q}; final result while out_valid.
- busy  output  1  state != IDLE.

## Operation
- Registers: a[N-1:0], q[N-1:0], m[N-1:0], sgn, count[$clog2(N)-1:0], state in {IDLE, RUN, DONE}.
- IDLE: accept on edge with in_valid & in_ready. Load a<=0, q<=multiplier, m<=multiplicand, sgn<=in_signed, count<=0, state<=RUN. Operands need not be held afterwards.
- RUN, one iteration per cycle:
  - Addend = q[0] ? m : 0.
  - Sum is computed N+1 bits wide.
    - Unsigned: {0,a} + {0,addend}.
    - Signed: sext(a) + sext(addend), except when count == N-1, where it is sext(a) - sext(addend). This is the sign-bit weight of Q.
  - Shift: {a,q} <= {sum[N:0], q[N-1:1]}.
  - count <= count+1.
  - On the iteration with count == N-1, state <= DONE.
- DONE: product holds until out_ready. On an edge with out_valid & out_ready, state <= IDLE; a, q and the product value are retained.
- in_valid while busy is ignored: no capture and no corruption.
- in_ready is never asserted in DONE. A new accept requires a return to IDLE first.
- Result is exact for all operand values: unsigned 0..(2^N-1)^2; signed, including (-2^(N-1)) * (-2^(N-1)) = 2^(2N-2).

## Timing
- Reset values:
  - Outputs: in_ready=1, out_valid=0, busy=0, product=0.
  - Internal registers: state=IDLE, a=q=m=count=0, sgn=0.
- Latency: accept edge E0; iterations on E1..EN; out_valid is high in the cycle after EN. That is N cycles from acceptance to valid.
- Throughput: one operation per N+2 cycles when out_ready is held high.
- out_valid is held, with product stable, for any number of out_ready-low cycles.
- Reset asserted mid-RUN or in DONE forces all reset values immediately, asynchronously. The partial result is discarded and out_valid is never raised for that operation.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- MULTIPLIER_SIGNED_EN:
  - Defined: signed mode as above, selected per operation by in_signed.
  - Undefined: in_signed is ignored, sgn logic and the subtract path are removed, and every operation is unsigned.

## Test plan
- N=4, unsigned 13 x 11: accept, out_valid exactly 4 cycles after the accept edge, product=0x8F. 15 x 15 -> 0xE1.
- N=4, signed (macro defined): -8 x 7 -> 0xC8; -8 x -8 -> 0x40; 5 x -3 -> 0xF1. The same bit patterns with in_signed=0 give 8 x 7 -> 0x38 and 8 x 8 -> 0x40.
- Backpressure: out_ready low for 10 cycles in DONE. out_valid and product stay stable, in_ready stays 0, and in_valid pulses are ignored. Raising out_ready returns to IDLE next edge.
- Back-to-back: in_valid held high with three operand pairs and out_ready=1. Results are in order, spaced N+2 cycles apart.
- Reset mid-RUN: assert n_reset two cycles after accept. Outputs return to reset values without a clock edge, and the next operation 3 x 5 -> 0x0F is correct.
- N=8 parameter check: unsigned 255 x 255 -> 0xFE01; signed -128 x -128 -> 0x4000; zero operand 0 x 0xAB -> 0.
